// File: rtl/peripheral_ahb3_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_ahb3_mem_slave
// Purpose  : AHB3-Lite slave backed by a flop word memory. It adds a
//            programmable number of wait states to each OKAY data phase and
//            gives a two-cycle ERROR response to illegal accesses.
// Option   : define PERIPHERAL_AHB3_MEM_PROT_EN to restrict the upper
//            quarter of the memory to privileged accesses (HPROT[1]=1).
// Revision : 1.0  initial release
// ============================================================================
module peripheral_ahb3_mem_slave #(
    parameter int HADDR_SIZE  = 16,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int         NB        = HDATA_SIZE / 8;
    localparam int         NBL       = (NB > 1) ? $clog2(NB) : 0;
    localparam int         OFFW      = (NBL > 0) ? NBL : 1;
    localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    take_d;
    logic [AW-1:0]           word_q;
    logic [OFFW-1:0]         offset_q;
    logic [2:0]              size_q;
    logic                    write_q;
    logic                    hreadyout_q, hresp_q;
    logic [HDATA_SIZE-1:0]   mem_q [MEM_DEPTH];

    logic                    w_accept, w_err, w_commit;
    logic [HADDR_SIZE-1:0]   w_word, w_align_mask;
    logic [OFFW-1:0]         w_offset;
    logic [NB-1:0]           w_be;
    logic                    w_unused;

    assign w_accept     = HSEL & HREADY & HTRANS[1];
    assign w_word       = HADDR >> NBL;
    assign w_offset     = (NBL > 0) ? HADDR[OFFW-1:0] : '0;
    assign w_align_mask = ~({HADDR_SIZE{1'b1}} << HSIZE);
    assign w_unused     = ^{HTRANS[0], HBURST, HMASTLOCK, HPROT};

    // The full address width takes part in the range check so aliasing above
    // the memory is reported instead of silently wrapping.
    always_comb begin
        w_err = (int'(HSIZE) > NBL)
             || ((HADDR & w_align_mask) != '0)
             || (w_word >= HADDR_SIZE'(MEM_DEPTH));
`ifdef PERIPHERAL_AHB3_MEM_PROT_EN
        if (!HPROT[1] && (w_word >= HADDR_SIZE'((3 * MEM_DEPTH) / 4)))
            w_err = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take_d  = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all hold while another slave stalls the bus
                if (HREADY) begin
                    state_d = ST_IDLE;
                    if (w_accept) begin
                        take_d = 1'b1;
                        if (w_err) begin
                            state_d = ST_ERR1;
                        end else if (WAIT_STATES > 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = WAIT_INIT;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            word_q      <= '0;
            offset_q    <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= (state_d != ST_WAIT) && (state_d != ST_ERR1);
            hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
            if (take_d) begin
                word_q   <= w_word[AW-1:0];
                offset_q <= w_offset;
                size_q   <= HSIZE;
                write_q  <= HWRITE;
            end
        end
    end

    always_comb begin
        w_be = '0;
        for (int b = 0; b < NB; b++)
            w_be[b] = (b >= int'(offset_q)) && (b < int'(offset_q) + (1 << size_q));
    end

    assign w_commit = (state_q == ST_DATA) && write_q && HREADY && !HRESET;

    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            for (int b = 0; b < NB; b++)
                if (w_be[b]) mem_q[word_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

    assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem_q[word_q] : '0;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule
`default_nettype wire

// File: doc/peripheral_ahb3_mem_slave.md
Name: peripheral_ahb3_mem_slave

Overview:
- Synthesizable AHB3-Lite slave with a flop-based word memory.
- Sits directly downstream of the AHB3 master BFM and is the bus target the BFM drives in block-level benches.
- Supports programmable wait states, byte/halfword/word lanes, and the two-cycle ERROR response for illegal accesses.

Parameters:
- HADDR_SIZE, 16, address bus width.
- HDATA_SIZE, 32, data bus width; power of two, at least 8.
- MEM_DEPTH, 256, number of HDATA_SIZE-bit words.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted before the final cycle of every OKAY data phase (0..15).

Ports:
- HCLK  input  1  clock; all state updates on rising edge.
- HRESET  input  1  synchronous active-high reset.
- HSEL  input  1  slave select.
- HADDR  input  HADDR_SIZE  byte address.
- HWDATA  input  HDATA_SIZE  write data, valid in the data phase.
- HRDATA  output  HDATA_SIZE  read data.
- HWRITE  input  1  1=write, 0=read.
- HSIZE  input  3  transfer size.
- HBURST  input  3  burst type; ignored (addresses are taken per beat).
- HPROT  input  4  protection; used only with the optional feature.
- HTRANS  input  2  IDLE/BUSY/NONSEQ/SEQ.
- HMASTLOCK  input  1  ignored.
- HREADY  input  1  bus ready (muxed HREADYOUT).
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (HRESET=1 at rising edge):
  - HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE.
  - Pending data-phase info is discarded; no write is committed.
  - Memory contents are not cleared.
- Address phase accepted when HSEL & HREADY & HTRANS[1]=1 at a rising edge. The slave latches addr, size, write, and the error flag.
- IDLE/BUSY or unselected: zero-wait OKAY data phase, no memory access.
- Lane math:
  - NB = HDATA_SIZE/8; offset = addr mod NB; word = addr/NB; bytes = 2^size.
- Error flag is set when any of these holds:
  - size > log2(NB);
  - addr not aligned to bytes;
  - word >= MEM_DEPTH.
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accepted OKAY transfer with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES-1.
    - Accepted OKAY transfer with WAIT_STATES=0 -> DATA.
    - Accepted error transfer -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0. This is the final data-phase cycle.
    - Write: at the closing edge, lanes offset..offset+bytes-1 of mem[word] are loaded from the same HWDATA lanes.
    - Read: HRDATA = mem[word] (full word, combinational from array), 0 in all other states.
    - A new address phase may be accepted at the same edge (pipelined): next state per the IDLE rules, else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No memory access. A transfer presented here is accepted per the IDLE rules.
- Read-after-write to the same word in back-to-back transfers returns the new data; the write commits before the read data phase.
- HADDR bits above the memory range participate only in the range check.
- HREADY low from another slave: no acceptance; the slave holds its state (only IDLE/DATA/ERR2 can observe this).

Optional Feature:
- Macro: PERIPHERAL_AHB3_MEM_PROT_EN.
- Defined: an access with HPROT[1]=0 (user) to the upper quarter of memory (word >= 3*MEM_DEPTH/4) sets the error flag. It takes the ERR1/ERR2 path and no write occurs.
- Undefined: HPROT is ignored and all in-range aligned accesses complete OKAY.

Test Plan:
- Word write, then read back: write 0xDEADBEEF at 0x0004 (HSIZE=2, SINGLE), read 0x0004 -> HRDATA=0xDEADBEEF, HRESP=0, HREADYOUT never low with WAIT_STATES=0.
- Byte write: write 0x11223344 at 0x0004, then byte write with HWDATA=0x00AB0000 at 0x0006 -> read 0x0004 returns 0x11AB3344.
- Wait states: WAIT_STATES=2, INCR4 write at 0x0010 of 1,2,3,4 -> each beat shows 2 cycles HREADYOUT=0 then 1 (12 data-phase cycles total); readback 1,2,3,4.
- Range error: MEM_DEPTH=256, word write at 0x0400 -> HREADYOUT/HRESP = 0/1 then 1/1; a prior value at 0x0000 is unchanged.
- Alignment/size error: halfword at 0x0001, and HSIZE=3 at 0x0008 -> each gives the two-cycle ERROR; a following OKAY read of 0x0004 completes normally.
- Reset mid-wait: WAIT_STATES=3, write 0x55AA55AA at 0x0020, assert HRESET in the 2nd wait cycle -> next cycle HREADYOUT=1, HRESP=0; readback of 0x0020 shows the old value.
